// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for the shared 2-bit 4:1 mux channel.
// Four requesters (A..D) compete for the channel. Each grant is bounded to
// HOLD_MAX transfers, and the granted symbol is registered onto the output
// together with a valid flag.
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [1:0] a_in,
  input  logic [1:0] b_in,
  input  logic [1:0] c_in,
  input  logic [1:0] d_in,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic [1:0] out,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_CNT = 4'(HOLD_MAX);

  state_t     state, state_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [1:0] sel_nxt;
  logic [3:0] count, count_nxt;
  logic [1:0] out_nxt;
  logic       valid_nxt;
  logic       release_now;

  logic [1:0] data_sel;
  logic [1:0] arb_base;
  logic       arb_found;
  logic [1:0] arb_winner;

  // The 4:1 data mux itself, steered by the current owner index
  always_comb begin
    case (sel)
      2'd0:    data_sel = a_in;
      2'd1:    data_sel = b_in;
      2'd2:    data_sel = c_in;
      default: data_sel = d_in;
    endcase
  end

  // Pick the first requester in rotating order; when idle the rotation starts
  // at the pointer, during ownership it starts just past the current owner so
  // that the owner itself is naturally last in line at a release
  always_comb begin
    logic [1:0] idx;
    arb_base   = (state == OWN) ? sel + 2'd1 : ptr;
    arb_found  = 1'b0;
    arb_winner = arb_base;
    idx        = arb_base;
    for (int i = 0; i < 4; i++) begin
      idx = arb_base + 2'(i);
      if (!arb_found && req[idx]) begin
        arb_found  = 1'b1;
        arb_winner = idx;
      end
    end
  end

  // Next-state logic: transfers, grant release and same-edge handoff
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    sel_nxt     = sel;
    count_nxt   = count;
    out_nxt     = out;
    valid_nxt   = 1'b0;
    release_now = 1'b0;
    case (state)
      IDLE: begin
        if (arb_found) begin
          sel_nxt   = arb_winner;
          count_nxt = 4'd0;
          state_nxt = OWN;
        end
      end
      OWN: begin
        if (req[sel]) begin
          out_nxt   = data_sel;
          valid_nxt = 1'b1;
          count_nxt = count + 4'd1;
          if (count + 4'd1 >= HOLD_CNT) begin
            release_now = 1'b1;
          end
        end else begin
          release_now = 1'b1;
        end
        if (release_now) begin
          ptr_nxt = sel + 2'd1;
          if (arb_found) begin
            sel_nxt   = arb_winner;
            count_nxt = 4'd0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      sel       <= 2'd0;
      count     <= 4'd0;
      out       <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      sel       <= sel_nxt;
      count     <= count_nxt;
      out       <= out_nxt;
      out_valid <= valid_nxt;
    end
  end

  assign busy = (state == OWN);
  assign gnt  = (state == OWN) ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: a vector table, directed corner
// sequences, and randomized traffic compared against a behavioural model.
module tb_mux4_rr_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [1:0] a_in, b_in, c_in, d_in;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [1:0] out;
  logic       out_valid;
  logic       busy;

  int checks = 0;
  int passes = 0;

  // Behavioural model state: owner index (-1 when idle), rotation start,
  // transfers so far in this grant, last owner, and output register
  int         m_owner;
  int         m_ptr;
  int         m_count;
  int         m_sel;
  logic [1:0] m_out;
  logic       m_valid;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [1:0] out;
    logic       vld;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  mux4_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .a_in(a_in),
    .b_in(b_in),
    .c_in(c_in),
    .d_in(d_in),
    .gnt(gnt),
    .sel(sel),
    .out(out),
    .out_valid(out_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic [3:0] q,
                               input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] c, input logic [1:0] d);
    reset = r;
    req   = q;
    a_in  = a;
    b_in  = b;
    c_in  = c;
    d_in  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] eg,
                             input logic [1:0] es, input logic [1:0] eo,
                             input logic ev, input logic eb);
    checks++;
    if ({gnt, sel, out, out_valid, busy} === {eg, es, eo, ev, eb}) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got gnt=%b sel=%0d out=%b valid=%b busy=%b, expected gnt=%b sel=%0d out=%b valid=%b busy=%b",
               name, gnt, sel, out, out_valid, busy, eg, es, eo, ev, eb);
    end
  endtask

  function automatic int firstReq(input logic [3:0] q, input int base);
    for (int k = 0; k < 4; k++) begin
      if (q[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  // One clock of the arbitration rules, written in terms of owners and turns
  task automatic modelStep(input logic r, input logic [3:0] q, input logic [7:0] dat);
    bit done;
    int w;
    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_sel   = 0;
      m_count = 0;
      m_out   = 2'b00;
      m_valid = 1'b0;
    end else if (m_owner < 0) begin
      m_valid = 1'b0;
      w = firstReq(q, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_sel   = w;
        m_count = 0;
      end
    end else begin
      done = 1'b0;
      if (q[m_owner]) begin
        m_out   = dat[2*m_owner +: 2];
        m_valid = 1'b1;
        m_count++;
        done = (m_count == HOLD);
      end else begin
        m_valid = 1'b0;
        done    = 1'b1;
      end
      if (done) begin
        m_ptr = (m_owner + 1) % 4;
        w = firstReq(q, m_ptr);
        if (w < 0) begin
          m_owner = -1;
        end else begin
          m_owner = w;
          m_sel   = w;
          m_count = 0;
        end
      end
    end
  endtask

  initial begin
    logic [3:0] rq;
    logic       rr;
    logic [7:0] dat;
    int         wait_cnt[4];
    int         max_wait;

    // Reset, then all four requesting with A=00 B=01 C=10 D=11
    tbl.push_back('{1'b1, 4'hF, 4'b0000, 2'd0, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'hF, 4'b0000, 2'd0, 2'b00, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'hF, 4'b0001, 2'd0, 2'b00, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 4'hF, 4'b0001, 2'd0, 2'b00, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'hF, 4'b0010, 2'd1, 2'b00, 1'b1, 1'b1});
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 4'hF, 4'b0010, 2'd1, 2'b01, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'hF, 4'b0100, 2'd2, 2'b01, 1'b1, 1'b1});
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 4'hF, 4'b0100, 2'd2, 2'b10, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'hF, 4'b1000, 2'd3, 2'b10, 1'b1, 1'b1});
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b0, 4'hF, 4'b1000, 2'd3, 2'b11, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'hF, 4'b0001, 2'd0, 2'b11, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'hF, 4'b0001, 2'd0, 2'b00, 1'b1, 1'b1});

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].rst, tbl[i].req, 2'b00, 2'b01, 2'b10, 2'b11);
      checkOutput($sformatf("table[%0d]", i), tbl[i].gnt, tbl[i].sel, tbl[i].out, tbl[i].vld, tbl[i].busy);
    end

    // Single requester C: continuous valid stream across re-grants
    applyStimulus(1'b1, 4'b0000, 2'b00, 2'b00, 2'b10, 2'b00);
    applyStimulus(1'b0, 4'b0100, 2'b00, 2'b00, 2'b10, 2'b00);
    checkOutput("single_grant", 4'b0100, 2'd2, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 4'b0100, 2'b00, 2'b00, 2'b10, 2'b00);
      checkOutput($sformatf("single_stream[%0d]", i), 4'b0100, 2'd2, 2'b10, 1'b1, 1'b1);
    end

    // Early release of B with D waiting: D granted at the dropping edge
    applyStimulus(1'b1, 4'b0000, 2'b00, 2'b01, 2'b10, 2'b11);
    applyStimulus(1'b0, 4'b0010, 2'b00, 2'b01, 2'b10, 2'b11);
    checkOutput("early_b_grant", 4'b0010, 2'd1, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 4'b0010, 2'b00, 2'b01, 2'b10, 2'b11);
      checkOutput($sformatf("early_b_xfer[%0d]", i), 4'b0010, 2'd1, 2'b01, 1'b1, 1'b1);
    end
    applyStimulus(1'b0, 4'b1000, 2'b00, 2'b01, 2'b10, 2'b11);
    checkOutput("early_d_handoff", 4'b1000, 2'd3, 2'b01, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b1000, 2'b00, 2'b01, 2'b10, 2'b11);
    checkOutput("early_d_xfer", 4'b1000, 2'd3, 2'b11, 1'b1, 1'b1);

    // Early release of B with C and D waiting: C comes before D
    applyStimulus(1'b1, 4'b0000, 2'b00, 2'b01, 2'b10, 2'b11);
    applyStimulus(1'b0, 4'b0010, 2'b00, 2'b01, 2'b10, 2'b11);
    applyStimulus(1'b0, 4'b0010, 2'b00, 2'b01, 2'b10, 2'b11);
    applyStimulus(1'b0, 4'b0010, 2'b00, 2'b01, 2'b10, 2'b11);
    applyStimulus(1'b0, 4'b1100, 2'b00, 2'b01, 2'b10, 2'b11);
    checkOutput("early_c_before_d", 4'b0100, 2'd2, 2'b01, 1'b0, 1'b1);

    // Reset in the middle of D's grant
    applyStimulus(1'b1, 4'b0000, 2'b00, 2'b01, 2'b10, 2'b11);
    applyStimulus(1'b0, 4'b1000, 2'b00, 2'b01, 2'b10, 2'b11);
    applyStimulus(1'b0, 4'b1000, 2'b00, 2'b01, 2'b10, 2'b11);
    applyStimulus(1'b0, 4'b1000, 2'b00, 2'b01, 2'b10, 2'b11);
    checkOutput("midreset_pre", 4'b1000, 2'd3, 2'b11, 1'b1, 1'b1);
    applyStimulus(1'b1, 4'b1000, 2'b00, 2'b01, 2'b10, 2'b11);
    checkOutput("midreset_cleared", 4'b0000, 2'd0, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b1001, 2'b00, 2'b01, 2'b10, 2'b11);
    checkOutput("midreset_a_first", 4'b0001, 2'd0, 2'b00, 1'b0, 1'b1);

    // A alone drops after one transfer: back to idle, output held
    applyStimulus(1'b1, 4'b0000, 2'b10, 2'b01, 2'b01, 2'b01);
    applyStimulus(1'b0, 4'b0001, 2'b10, 2'b01, 2'b01, 2'b01);
    applyStimulus(1'b0, 4'b0001, 2'b10, 2'b01, 2'b01, 2'b01);
    checkOutput("idle_a_xfer", 4'b0001, 2'd0, 2'b10, 1'b1, 1'b1);
    applyStimulus(1'b0, 4'b0000, 2'b10, 2'b01, 2'b01, 2'b01);
    checkOutput("idle_release", 4'b0000, 2'd0, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 2'b10, 2'b01, 2'b01, 2'b01);
    checkOutput("idle_hold", 4'b0000, 2'd0, 2'b10, 1'b0, 1'b0);

    // Randomized traffic against the model, plus a starvation watch
    max_wait = 0;
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    rq = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      rr  = (n == 0) || ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      dat = 8'($urandom_range(0, 255));
      modelStep(rr, rq, dat);
      applyStimulus(rr, rq, dat[1:0], dat[3:2], dat[5:4], dat[7:6]);
      checkOutput($sformatf("random[%0d]", n),
                  (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner),
                  2'(m_sel), m_out, m_valid, (m_owner >= 0));
      for (int i = 0; i < 4; i++) begin
        if (!rr && rq[i] && !gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
    checks++;
    if (max_wait <= 3*HOLD + 3) passes++;
    else $display("[TB] FAIL fairness: longest wait %0d cycles, required at most %0d", max_wait, 3*HOLD + 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
